// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and sizing for the integer register file and its scoreboard.
package reg_file_pkg;
    typedef logic [31:0] data_t;
    typedef logic [4:0]  reg_idx_t;
    localparam data_t NULL     = '0;
    localparam int    RF_NREG  = 32;
    localparam int    RF_CNT_W = 2;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating pending-write counter for one register, flags protocol violations.
module sb_counter
    import reg_file_pkg::*;
#(
    parameter int CNT_W = RF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic [1:0] dec,
    output logic       zero,
    output logic       one,
    output logic       err
);
    localparam int W   = CNT_W + 1;
    localparam int MAX = 2 ** CNT_W - 1;

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [W-1:0]     sum, dw, diff;
    logic             under, over;

    // Evaluate inc and dec together so a simultaneous pair cancels without tripping a bound.
    always_comb begin
        sum      = {1'b0, cnt} + W'(inc);
        dw       = W'(dec);
        diff     = sum - dw;
        under    = dw > sum;
        over     = !under && diff > W'(MAX);
        cnt_next = under ? '0 : over ? CNT_W'(MAX) : diff[CNT_W-1:0];
        err      = under || over || (dec == 2'd2 && cnt < CNT_W'(2));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;

    assign zero = cnt == '0;
    assign one  = cnt == CNT_W'(1);
endmodule

// File: rtl/reg_file.sv
// reg_file: x0-x31 register file with writeback bypass and a per-register pending-write
// scoreboard that stalls decode on unresolved sources.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int CNT_W = RF_CNT_W
) (
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t rs1_addr,
    input  reg_idx_t rs2_addr,
    input  logic     rs1_used,
    input  logic     rs2_used,
    output data_t    rs1_data,
    output data_t    rs2_data,
    input  logic     issue_valid,
    input  logic     issue_wr,
    input  reg_idx_t issue_rd,
    input  logic     wb_en,
    input  reg_idx_t wb_rd,
    input  data_t    wb_data,
    input  logic     squash_valid,
    input  reg_idx_t squash_rd,
    output logic     stall,
    output logic     sb_err
);
    data_t           regs [NREG];
    logic [NREG-1:0] zero, one, err;
    logic            issue_ok, haz1, haz2;

    // x0 never has a pending writer, so its flags are constant.
    assign zero[0] = 1'b1;
    assign one[0]  = 1'b0;
    assign err[0]  = 1'b0;

    assign issue_ok = issue_valid && issue_wr && !stall;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (issue_ok && issue_rd == reg_idx_t'(g)),
            .dec  ({1'b0, wb_en && wb_rd == reg_idx_t'(g)} +
                   {1'b0, squash_valid && squash_rd == reg_idx_t'(g)}),
            .zero (zero[g]),
            .one  (one[g]),
            .err  (err[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < NREG; i++) regs[i] <= NULL;
        else if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;

    assign rs1_data = (!rst_n || rs1_addr == '0) ? NULL :
                      (wb_en && wb_rd == rs1_addr) ? wb_data : regs[rs1_addr];
    assign rs2_data = (!rst_n || rs2_addr == '0) ? NULL :
                      (wb_en && wb_rd == rs2_addr) ? wb_data : regs[rs2_addr];

    // A last outstanding writer retiring this cycle is covered by the bypass.
    assign haz1  = rs1_used && !zero[rs1_addr] && !(one[rs1_addr] && wb_en && wb_rd == rs1_addr);
    assign haz2  = rs2_used && !zero[rs2_addr] && !(one[rs2_addr] && wb_en && wb_rd == rs2_addr);
    assign stall = rst_n && (haz1 || haz2);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    sb_err <= 1'b0;
        else if (|err) sb_err <= 1'b1;
endmodule
